// File: rtl/ah_snoop_hazard_gate_pkg.sv
// Shared types and default widths for the snoop hazard gate.
// The gate FSM only ever holds one request at a time.
package ah_snoop_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SNOOP = 2'd1,
        ISSUE = 2'd2
    } state_t;

    localparam int DEF_KEY_W  = 16;
    localparam int DEF_DATA_W = 132;

endpackage

// File: rtl/ah_snoop_hazard_gate_sat_counter.sv
// Saturating up-counter with synchronous clear.
// It sticks at all-ones instead of wrapping.
module ah_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_inc,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/ah_snoop_hazard_gate.sv
// Read-side hazard gate: holds a read request until the write FIFO reports no pending
// write with the same key, then releases it downstream (or forces it out after TIMEOUT).
module ah_snoop_hazard_gate
    import ah_snoop_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int KEY_W   = DEF_KEY_W,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] req_data,
    input  logic              req_valid,
    output logic              req_ready,
    output logic [KEY_W-1:0]  sdata,
    output logic              svalid,
    input  logic              smatch,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic              busy
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    state_t              r_state;
    state_t              w_nextState;
    logic [DATA_W-1:0]   r_hold;
    logic [WAIT_W-1:0]   r_waitCnt;
    logic                r_err;
    logic [WAIT_W-1:0]   w_waitNext;
    logic                w_snoopMatch;
    logic                w_timeoutHit;

    // smatch only matters while we are actually strobing the snoop port.
    assign w_snoopMatch = (r_state == SNOOP) && smatch;
    assign w_waitNext   = r_waitCnt + WAIT_W'(1);
    assign w_timeoutHit = w_snoopMatch && (w_waitNext == WAIT_W'(TIMEOUT));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_nextState = SNOOP;
            SNOOP:   if (!smatch || w_timeoutHit) w_nextState = ISSUE;
            ISSUE:   if (out_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // err is rewritten on every SNOOP cycle, so it reflects how the last snoop ended.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_hold    <= '0;
            r_waitCnt <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_hold    <= req_data;
                        r_waitCnt <= '0;
                    end
                end
                SNOOP: begin
                    if (smatch) begin
                        r_waitCnt <= w_waitNext;
                    end
                    r_err <= w_timeoutHit;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready = 1'b0;
        svalid    = 1'b0;
        sdata     = '0;
        out_valid = 1'b0;
        out_data  = '0;
        out_err   = 1'b0;
        case (r_state)
            IDLE:  req_ready = 1'b1;
            SNOOP: begin
                svalid = 1'b1;
                sdata  = r_hold[KEY_W-1:0];
            end
            ISSUE: begin
                out_valid = 1'b1;
                out_data  = r_hold;
                out_err   = r_err;
            end
            default: ;
        endcase
    end

    assign busy = (r_state != IDLE);

    ah_sat_counter #(
        .WIDTH(CNT_W)
    ) uStallCnt (
        .clk    (clk),
        .rstn   (rstn),
        .i_inc  (w_snoopMatch),
        .i_clear(1'b0),
        .o_count(stall_cnt)
    );

endmodule

// File: tb/tb_ah_snoop_hazard_gate.sv
// Randomized bench for ah_snoop_hazard_gate; a transaction-level model predicts snoop length,
// release timing, error flag and stall totals. A second instance with a 4-bit counter shares stimulus.
module tb_ah_snoop_hazard_gate;

    localparam int DATA_W  = 132;
    localparam int KEY_W   = 16;
    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 32;
    localparam int SMALL_W = 4;

    logic              clk = 1'b0;
    logic              rstn;
    logic [DATA_W-1:0] req_data;
    logic              req_valid;
    logic              smatch;
    logic              out_ready;

    logic              req_ready, svalid, out_valid, out_err, busy;
    logic [KEY_W-1:0]  sdata;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  stall_cnt;

    logic               sReqReady, sSvalid, sOutValid, sOutErr, sBusy;
    logic [KEY_W-1:0]   sSdata;
    logic [DATA_W-1:0]  sOutData;
    logic [SMALL_W-1:0] sStallCnt;

    int     nChecks = 0;
    int     nFails  = 0;
    longint expStall;
    longint expSmall;

    always #5 clk = ~clk;

    ah_snoop_hazard_gate #(
        .DATA_W(DATA_W), .KEY_W(KEY_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rstn(rstn), .req_data(req_data), .req_valid(req_valid),
        .req_ready(req_ready), .sdata(sdata), .svalid(svalid), .smatch(smatch),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_err(out_err), .stall_cnt(stall_cnt), .busy(busy)
    );

    ah_snoop_hazard_gate #(
        .DATA_W(DATA_W), .KEY_W(KEY_W), .TIMEOUT(TIMEOUT), .CNT_W(SMALL_W)
    ) dutSmall (
        .clk(clk), .rstn(rstn), .req_data(req_data), .req_valid(req_valid),
        .req_ready(sReqReady), .sdata(sSdata), .svalid(sSvalid), .smatch(smatch),
        .out_data(sOutData), .out_valid(sOutValid), .out_ready(out_ready),
        .out_err(sOutErr), .stall_cnt(sStallCnt), .busy(sBusy)
    );

    task automatic checkOutput(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] randData();
        logic [159:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[DATA_W-1:0];
    endfunction

    function automatic longint satAdd(input longint base, input longint inc, input int width);
        longint maxVal;
        maxVal = (longint'(1) << width) - 1;
        return (base + inc > maxVal) ? maxVal : base + inc;
    endfunction

    // One full request: accept, snoop with nMatch leading matches, then hold in ISSUE for readyDelay cycles.
    task automatic applyStimulus(input logic [DATA_W-1:0] data, input int nMatch, input int readyDelay);
        int     expSnoop;
        logic   expErr;
        longint inc;
        expErr   = (nMatch >= TIMEOUT);
        expSnoop = expErr ? TIMEOUT : nMatch + 1;
        inc      = expErr ? TIMEOUT : nMatch;

        @(negedge clk);
        checkOutput("idle_req_ready", req_ready, 1);
        checkOutput("idle_out_valid", out_valid, 0);
        checkOutput("idle_busy", busy, 0);
        req_data  = data;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_data  = randData();
        out_ready = 1'($urandom_range(0, 1));

        for (int k = 0; k < expSnoop; k++) begin
            smatch = (k < nMatch);
            @(negedge clk);
            checkOutput("snoop_svalid", svalid, 1);
            checkOutput("snoop_sdata", sdata, data[KEY_W-1:0]);
            checkOutput("snoop_req_ready", req_ready, 0);
            checkOutput("snoop_out_valid", out_valid, 0);
            checkOutput("snoop_busy", busy, 1);
            checkOutput("snoop_stall", stall_cnt, satAdd(expStall, k, CNT_W));
            checkOutput("snoop_small_stall", sStallCnt, satAdd(expSmall, k, SMALL_W));
            @(posedge clk);
            #1;
        end

        smatch    = 1'($urandom_range(0, 1));
        out_ready = (readyDelay == 0);
        expStall  = satAdd(expStall, inc, CNT_W);
        expSmall  = satAdd(expSmall, inc, SMALL_W);

        @(negedge clk);
        checkOutput("issue_svalid", svalid, 0);
        checkOutput("issue_sdata", sdata, 0);
        checkOutput("issue_out_valid", out_valid, 1);
        checkOutput("issue_out_data", out_data, data);
        checkOutput("issue_out_err", out_err, expErr);
        checkOutput("issue_req_ready", req_ready, 0);
        checkOutput("issue_stall", stall_cnt, expStall);
        checkOutput("small_stall", sStallCnt, expSmall);
        checkOutput("small_out_valid", sOutValid, 1);
        checkOutput("small_out_data", sOutData, data);
        checkOutput("small_out_err", sOutErr, expErr);
        checkOutput("small_misc", {sReqReady, sSvalid, sBusy, sSdata}, {3'b001, 16'h0});

        for (int d = 0; d < readyDelay; d++) begin
            @(posedge clk);
            #1;
            if (d == readyDelay - 1) out_ready = 1'b1;
            @(negedge clk);
            checkOutput("hold_out_valid", out_valid, 1);
            checkOutput("hold_out_data", out_data, data);
            checkOutput("hold_out_err", out_err, expErr);
            checkOutput("hold_req_ready", req_ready, 0);
            checkOutput("hold_stall", stall_cnt, expStall);
        end

        @(posedge clk);
        #1;
        out_ready = 1'($urandom_range(0, 1));
    endtask

    initial begin
        logic [DATA_W-1:0] d0;
        int                n;
        int                pick;

        rstn      = 1'b0;
        req_valid = 1'b0;
        req_data  = '0;
        smatch    = 1'b0;
        out_ready = 1'b0;
        expStall  = 0;
        expSmall  = 0;

        repeat (3) @(negedge clk);
        checkOutput("rst_req_ready", req_ready, 1);
        checkOutput("rst_svalid", svalid, 0);
        checkOutput("rst_sdata", sdata, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_out_err", out_err, 0);
        checkOutput("rst_stall", stall_cnt, 0);
        checkOutput("rst_busy", busy, 0);
        rstn = 1'b1;

        d0 = randData();
        d0[KEY_W-1:0] = 16'hABCD;
        applyStimulus(d0, 0, 0);
        applyStimulus(randData(), 3, 0);
        applyStimulus(randData(), 1, 5);

        // Reset in the middle of a stalled snoop must drop the request silently.
        @(negedge clk);
        req_data  = randData();
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        smatch    = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        expStall = 0;
        expSmall = 0;
        checkOutput("mid_rst_req_ready", req_ready, 1);
        checkOutput("mid_rst_svalid", svalid, 0);
        checkOutput("mid_rst_sdata", sdata, 0);
        checkOutput("mid_rst_out", {out_valid, out_err, out_data}, 0);
        checkOutput("mid_rst_stall", stall_cnt, 0);
        checkOutput("mid_rst_small_stall", sStallCnt, 0);
        checkOutput("mid_rst_busy", busy, 0);
        @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            smatch = 1'($urandom_range(0, 1));
            @(negedge clk);
            checkOutput("post_rst_out_valid", out_valid, 0);
            checkOutput("post_rst_svalid", svalid, 0);
            checkOutput("post_rst_stall", stall_cnt, 0);
        end
        smatch = 1'b0;

        applyStimulus(randData(), 200, 0);

        for (int t = 0; t < 30; t++) begin
            pick = $urandom_range(0, 9);
            if (pick < 5)      n = $urandom_range(0, 5);
            else if (pick < 8) n = $urandom_range(6, TIMEOUT - 1);
            else               n = $urandom_range(TIMEOUT, TIMEOUT + 10);
            applyStimulus(randData(), n, $urandom_range(0, 4));
        end

        @(negedge clk);
        checkOutput("final_stall", stall_cnt, expStall);
        checkOutput("final_small_stall", sStallCnt, expSmall);

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end

endmodule
